mips_mc_ctrl: RTL and testbench

Multicycle MIPS main controller: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback steps and drives the datapath enables and mux selects. It produces the 2-bit `aluop` consumed by the ALU decoder, which maps `aluop`/`funct` to `alucontrol`. It sits beside that decoder in the multicycle datapath controller. Memory accesses use a `mem_ready` handshake, so variable-latency memory stalls the sequence.

---
 rtl/mips_pkg.sv | 60 ++++++
 rtl/mips_mc_outdec.sv | 78 +++++++
 rtl/mips_mc_ctrl.sv | 107 ++++++++++
 tb/tb_mips_mc_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   mc_state_t  : 4-bit controller state encoding
//   OP_*        : opcode field values decoded in DECODE / MEMADR
//   ALUOP_*     : aluop encodings consumed by the ALU decoder
//   SRCB_*/PCSRC_* : datapath mux select encodings
//   mc_ctrl_t   : control word produced by the state decoder
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } mc_ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational state-to-control-word decoder for the multicycle controller.
// Ports:
//   state     in  current controller state
//   mem_ready in  memory handshake; gates the FETCH write enables
//   ctrl      out control word (datapath enables, mux selects, pcwrite, branch)
module mips_mc_outdec
    import mips_pkg::*;
(
    input  mc_state_t state,
    input  logic      mem_ready,
    output mc_ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                // IR and PC only load once the instruction word is actually back.
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            DECODE: begin
                ctrl.alusrcb = SRCB_IMM2;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                // Strobe is held for the whole stall until memory accepts it.
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            JUMP: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller (Moore FSM with mem_ready stalls).
// Ports:
//   clk, reset (async, active-low; low forces FETCH)
//   op, zero, mem_ready                 : inputs from IR, ALU and memory
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
//   alusrcb, aluop, pcsrc, pcen         : datapath controls
//   illegal                             : one-cycle pulse in DECODE on unknown opcode
// Configuration macro: MIPS_MC_BNE_EN adds bne (opcode 000101) via the BRANCH
// state with an inverted zero test; when undefined 000101 is illegal.
module mips_mc_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal
);

    mc_state_t state, state_next;
    mc_ctrl_t  ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        illegal    = 1'b0;
        case (state)
            FETCH:   if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:       state_next = BRANCH;
`endif
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default: begin
                        state_next = FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_next = MEMWB;
            MEMWB:   state_next = FETCH;
            MEMWR:   if (mem_ready) state_next = FETCH;
            EXECUTE: state_next = ALUWB;
            ALUWB:   state_next = FETCH;
            BRANCH:  state_next = FETCH;
            ADDIEX:  state_next = ADDIWB;
            ADDIWB:  state_next = FETCH;
            JUMP:    state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    mips_mc_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

`ifdef MIPS_MC_BNE_EN
    // Remembers that the branch in flight is bne so BRANCH inverts the zero test.
    logic bne_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               bne_q <= 1'b0;
        else if (state == DECODE && op == OP_BNE) bne_q <= 1'b1;
        else if (state == FETCH)                  bne_q <= 1'b0;
    end

    assign pcen = ctrl.pcwrite | (ctrl.branch & (zero ^ bne_q));
`else
    assign pcen = ctrl.pcwrite | (ctrl.branch & zero);
`endif

    assign iord     = ctrl.iord;
    assign memwrite = ctrl.memwrite;
    assign irwrite  = ctrl.irwrite;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign regwrite = ctrl.regwrite;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign aluop    = ctrl.aluop;
    assign pcsrc    = ctrl.pcsrc;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: each driven cycle pushes the expected
// 16-bit control word; a negedge monitor pops and compares.
// Word: {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,
//        aluop,pcsrc,pcen,illegal,1'b0}
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcen, illegal;

    mips_mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .iord      (iord),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .pcsrc     (pcsrc),
        .pcen      (pcen),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] B_IORD   = 16'h8000;
    localparam logic [15:0] B_MEMW   = 16'h4000;
    localparam logic [15:0] B_IRW    = 16'h2000;
    localparam logic [15:0] B_REGDST = 16'h1000;
    localparam logic [15:0] B_M2R    = 16'h0800;
    localparam logic [15:0] B_REGW   = 16'h0400;
    localparam logic [15:0] B_SRCA   = 16'h0200;
    localparam logic [15:0] B_SRCB4  = 16'h0080;
    localparam logic [15:0] B_SRCBI  = 16'h0100;
    localparam logic [15:0] B_SRCBS  = 16'h0180;
    localparam logic [15:0] B_SUB    = 16'h0020;
    localparam logic [15:0] B_FUNCT  = 16'h0040;
    localparam logic [15:0] B_PCOUT  = 16'h0008;
    localparam logic [15:0] B_PCJ    = 16'h0010;
    localparam logic [15:0] B_PCEN   = 16'h0004;
    localparam logic [15:0] B_ILL    = 16'h0002;

    localparam logic [15:0] W_FWAIT  = B_SRCB4;
    localparam logic [15:0] W_FGO    = B_SRCB4 | B_IRW | B_PCEN;
    localparam logic [15:0] W_DEC    = B_SRCBS;
    localparam logic [15:0] W_DECILL = B_SRCBS | B_ILL;
    localparam logic [15:0] W_MADR   = B_SRCA | B_SRCBI;
    localparam logic [15:0] W_MRD    = B_IORD;
    localparam logic [15:0] W_MWB    = B_M2R | B_REGW;
    localparam logic [15:0] W_MWR    = B_IORD | B_MEMW;
    localparam logic [15:0] W_EXEC   = B_SRCA | B_FUNCT;
    localparam logic [15:0] W_ALUWB  = B_REGDST | B_REGW;
    localparam logic [15:0] W_BR     = B_SRCA | B_SUB | B_PCOUT;
    localparam logic [15:0] W_AEX    = B_SRCA | B_SRCBI;
    localparam logic [15:0] W_AWB    = B_REGW;
    localparam logic [15:0] W_JUMP   = B_PCJ | B_PCEN;

    wire [15:0] outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                        alusrcb, aluop, pcsrc, pcen, illegal, 1'b0};

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [15:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, outs, e);
        end
    end

    // Drive one cycle's inputs and queue the control word expected in that cycle.
    task automatic cyc(input string tag, input logic [5:0] o, input logic z,
                       input logic mr, input logic [15:0] exp);
        op        = o;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        op        = 6'b0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #2;
        chk("reset", outs, W_FWAIT);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // fetch stall
        cyc("fetch_stall0", 6'b0, 1'b0, 1'b0, W_FWAIT);
        cyc("fetch_stall1", 6'b0, 1'b0, 1'b0, W_FWAIT);

        // lw, no stalls: 5 cycles
        cyc("lw_f",    6'b100011, 1'b0, 1'b1, W_FGO);
        cyc("lw_d",    6'b100011, 1'b0, 1'b1, W_DEC);
        cyc("lw_adr",  6'b100011, 1'b0, 1'b1, W_MADR);
        cyc("lw_rd",   6'b100011, 1'b0, 1'b1, W_MRD);
        cyc("lw_wb",   6'b100011, 1'b0, 1'b1, W_MWB);

        // lw with two wait cycles in MEMRD
        cyc("lws_f",   6'b100011, 1'b0, 1'b1, W_FGO);
        cyc("lws_d",   6'b100011, 1'b0, 1'b0, W_DEC);
        cyc("lws_adr", 6'b100011, 1'b0, 1'b0, W_MADR);
        cyc("lws_rd0", 6'b100011, 1'b0, 1'b0, W_MRD);
        cyc("lws_rd1", 6'b100011, 1'b0, 1'b0, W_MRD);
        cyc("lws_rd2", 6'b100011, 1'b0, 1'b1, W_MRD);
        cyc("lws_wb",  6'b100011, 1'b0, 1'b0, W_MWB);

        // sw with three wait cycles: memwrite for 4 cycles, then FETCH
        cyc("sw_f",    6'b101011, 1'b0, 1'b1, W_FGO);
        cyc("sw_d",    6'b101011, 1'b0, 1'b1, W_DEC);
        cyc("sw_adr",  6'b101011, 1'b0, 1'b1, W_MADR);
        cyc("sw_wr0",  6'b101011, 1'b0, 1'b0, W_MWR);
        cyc("sw_wr1",  6'b101011, 1'b0, 1'b0, W_MWR);
        cyc("sw_wr2",  6'b101011, 1'b0, 1'b0, W_MWR);
        cyc("sw_wr3",  6'b101011, 1'b0, 1'b1, W_MWR);
        cyc("sw_next", 6'b101011, 1'b0, 1'b0, W_FWAIT);

        // R-type
        cyc("r_f",     6'b000000, 1'b0, 1'b1, W_FGO);
        cyc("r_d",     6'b000000, 1'b0, 1'b1, W_DEC);
        cyc("r_ex",    6'b000000, 1'b0, 1'b1, W_EXEC);
        cyc("r_wb",    6'b000000, 1'b0, 1'b1, W_ALUWB);

        // addi
        cyc("ai_f",    6'b001000, 1'b0, 1'b1, W_FGO);
        cyc("ai_d",    6'b001000, 1'b0, 1'b1, W_DEC);
        cyc("ai_ex",   6'b001000, 1'b0, 1'b1, W_AEX);
        cyc("ai_wb",   6'b001000, 1'b0, 1'b1, W_AWB);

        // beq taken / not taken
        cyc("beq1_f",  6'b000100, 1'b0, 1'b1, W_FGO);
        cyc("beq1_d",  6'b000100, 1'b0, 1'b1, W_DEC);
        cyc("beq1_br", 6'b000100, 1'b1, 1'b1, W_BR | B_PCEN);
        cyc("beq0_f",  6'b000100, 1'b1, 1'b1, W_FGO);
        cyc("beq0_d",  6'b000100, 1'b1, 1'b1, W_DEC);
        cyc("beq0_br", 6'b000100, 1'b0, 1'b1, W_BR);

        // jump
        cyc("j_f",     6'b000010, 1'b0, 1'b1, W_FGO);
        cyc("j_d",     6'b000010, 1'b0, 1'b1, W_DEC);
        cyc("j_j",     6'b000010, 1'b0, 1'b1, W_JUMP);

        // illegal opcode: one-cycle pulse, back to FETCH
        cyc("ill_f",   6'b111111, 1'b0, 1'b1, W_FGO);
        cyc("ill_d",   6'b111111, 1'b0, 1'b1, W_DECILL);
        cyc("ill_nx",  6'b111111, 1'b0, 1'b0, W_FWAIT);

`ifdef MIPS_MC_BNE_EN
        cyc("bne0_f",  6'b000101, 1'b1, 1'b1, W_FGO);
        cyc("bne0_d",  6'b000101, 1'b1, 1'b1, W_DEC);
        cyc("bne0_br", 6'b000101, 1'b0, 1'b1, W_BR | B_PCEN);
        cyc("bne1_f",  6'b000101, 1'b0, 1'b1, W_FGO);
        cyc("bne1_d",  6'b000101, 1'b0, 1'b1, W_DEC);
        cyc("bne1_br", 6'b000101, 1'b1, 1'b1, W_BR);
        // beq right after bne must use the plain zero test again
        cyc("bq_f",    6'b000100, 1'b0, 1'b1, W_FGO);
        cyc("bq_d",    6'b000100, 1'b0, 1'b1, W_DEC);
        cyc("bq_br",   6'b000100, 1'b1, 1'b1, W_BR | B_PCEN);
`else
        cyc("bne_f",   6'b000101, 1'b0, 1'b1, W_FGO);
        cyc("bne_d",   6'b000101, 1'b0, 1'b1, W_DECILL);
        cyc("bne_nx",  6'b000101, 1'b0, 1'b0, W_FWAIT);
`endif

        // reset asserted during EXECUTE
        cyc("rm_f",    6'b000000, 1'b0, 1'b1, W_FGO);
        cyc("rm_d",    6'b000000, 1'b0, 1'b1, W_DEC);
        op        = 6'b000000;
        mem_ready = 1'b0;
        exp_q.push_back(W_EXEC);
        tag_q.push_back("rm_ex");
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid", outs, W_FWAIT);
        @(posedge clk);
        #1;
        chk("rst_hold", outs, W_FWAIT);
        reset = 1'b1;
        cyc("rr_fw",   6'b000010, 1'b0, 1'b0, W_FWAIT);
        cyc("rr_f",    6'b000010, 1'b0, 1'b1, W_FGO);
        cyc("rr_d",    6'b000010, 1'b0, 1'b1, W_DEC);
        cyc("rr_j",    6'b000010, 1'b0, 1'b1, W_JUMP);

        @(posedge clk);
        #1;
        chk("drain", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
